// File: rtl/rotfpga_scan_pkg.sv
// Shared types and helpers for the rotating-tile FPGA configuration-scan controller.
package rotfpga_scan_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    READBACK = 2'd2,
    DONE     = 2'd3
  } scan_state_t;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  // Bits needed to index n distinct values (never less than one).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One MSB-first step of the serial CRC-8.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/rotfpga_scan_ctrl_crc8.sv
// Serial CRC-8 accumulator for the scan load stream (used when ROTFPGA_SCAN_CRC_EN is defined).
module rotfpga_crc8
  import rotfpga_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;

  // A clear that coincides with a bit restarts the CRC from that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc8_step(i_clear ? {CRC_W{1'b0}} : r_crc, i_bit);
    end else if (i_clear) begin
      r_crc <= '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/rotfpga_scan_ctrl.sv
// Configuration-scan controller: host serial stream -> CHAINS parallel tile chains, plus readback.
// Optional CRC-8 trailer check is enabled by defining ROTFPGA_SCAN_CRC_EN.
module rotfpga_scan_ctrl
  import rotfpga_scan_pkg::*;
#(
  parameter int CHAINS    = 4,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = cnt_width(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_se,
  input  logic              host_sc,
  input  logic              host_rb,
  output logic              host_sc_out,
  output logic              chain_se,
  output logic [CHAINS-1:0] chain_di,
  input  logic [CHAINS-1:0] chain_do,
  output logic              busy,
  output logic              done,
  output logic              err,
  output scan_state_t       o_dbg_state
);

  // Chain handshake: chain_se is a one-cycle valid strobe qualifying chain_di;
  // the chains always accept it (no ready), so every strobe is one shift.

  localparam int BIT_W = cnt_width(CHAINS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAINS - 1);
  localparam logic [CNT_W-1:0] WORDS    = CNT_W'(CHAIN_LEN);

  scan_state_t       r_state, w_next;
  logic [BIT_W-1:0]  r_bitcnt, w_bit_inc;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CHAINS-1:0] r_staging, r_oshift, r_chain_di, w_word;
  logic              r_chain_se, r_sc_out, r_err;
  logic              w_data_phase, w_capture, w_word_full, w_rb_strobe, w_err_set;

  assign w_data_phase = (r_word_cnt != WORDS);
  assign w_capture    = host_se & ((r_state == IDLE) | ((r_state == LOAD) & w_data_phase));
  assign w_word_full  = w_capture & (r_bitcnt == LAST_BIT);
  assign w_bit_inc    = (r_bitcnt == LAST_BIT) ? '0 : r_bitcnt + BIT_W'(1);
  assign w_rb_strobe  = (r_state == READBACK) & (r_bitcnt == '0) & w_data_phase;

  always_comb begin
    w_word           = r_staging;
    w_word[r_bitcnt] = host_sc;
  end

`ifdef ROTFPGA_SCAN_CRC_EN
  logic [CRC_W-1:0] w_crc;
  logic [3:0]       r_trl_cnt;
  logic             w_trl_bit, w_trl_last, w_crc_bad;

  assign w_trl_bit  = host_se & (r_state == LOAD) & ~w_data_phase;
  assign w_trl_last = w_trl_bit & (r_trl_cnt == 4'(CRC_W - 1));
  // Residue after the final trailer bit must be zero for a clean load.
  assign w_crc_bad  = (crc8_step(w_crc, host_sc) != '0);

  rotfpga_crc8 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (r_state == IDLE),
    .i_en    (w_capture | w_trl_bit),
    .i_bit   (host_sc),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trl_cnt <= '0;
    end else if (w_next == IDLE) begin
      r_trl_cnt <= '0;
    end else if (w_trl_bit) begin
      r_trl_cnt <= r_trl_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (host_se) w_next = LOAD;
        else if (host_rb) w_next = READBACK;
      end
      LOAD: begin
        if (w_data_phase) begin
          if (!host_se) w_next = IDLE;
        end
`ifdef ROTFPGA_SCAN_CRC_EN
        else if (!host_se) w_next = IDLE;
        else if (w_trl_last) w_next = DONE;
`else
        else w_next = DONE;
`endif
      end
      READBACK: begin
        if ((r_bitcnt == '0) && !w_data_phase) w_next = DONE;
      end
      DONE: begin
        if (!host_se && !host_rb) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_err_set = 1'b0;
    case (r_state)
      LOAD: begin
`ifdef ROTFPGA_SCAN_CRC_EN
        w_err_set = (w_next == IDLE) | (w_trl_last & w_crc_bad);
`else
        w_err_set = (w_next == IDLE) | (host_se & ~w_data_phase);
`endif
      end
      READBACK, DONE: w_err_set = host_se;
      default:        w_err_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt   <= '0;
      r_word_cnt <= '0;
      r_staging  <= '0;
      r_oshift   <= '0;
      r_chain_di <= '0;
      r_chain_se <= 1'b0;
      r_sc_out   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_chain_se <= 1'b0;
      r_chain_di <= '0;
      r_sc_out   <= 1'b0;
      if (w_next == IDLE) begin
        r_bitcnt   <= '0;
        r_word_cnt <= '0;
        r_staging  <= '0;
        r_oshift   <= '0;
      end else if (w_capture) begin
        r_bitcnt  <= w_bit_inc;
        r_staging <= w_word_full ? '0 : w_word;
        if (w_word_full) begin
          r_chain_se <= 1'b1;
          r_chain_di <= w_word;
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
      end else if (r_state == READBACK) begin
        // Tail word is captured on the strobe cycle; its bit 0 goes out immediately.
        if (w_rb_strobe) begin
          r_oshift   <= chain_do;
          r_sc_out   <= chain_do[0];
          r_word_cnt <= r_word_cnt + CNT_W'(1);
          r_bitcnt   <= w_bit_inc;
        end else if (r_bitcnt != '0) begin
          r_sc_out <= r_oshift[r_bitcnt];
          r_bitcnt <= w_bit_inc;
        end
      end
      if ((r_state == IDLE) && host_se) r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    busy        = (r_state == LOAD) | (r_state == READBACK);
    done        = (r_state == DONE);
    chain_se    = r_chain_se | w_rb_strobe;
    chain_di    = (r_state == READBACK) ? chain_do : r_chain_di;
    host_sc_out = r_sc_out;
    err         = r_err;
    o_dbg_state = r_state;
  end

endmodule
